// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared defaults and FSM state type for the PWM capture block
package pwm_pkg;

    localparam int CNT_WIDTH_DEFAULT   = 16;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - input synchronizer with single-cycle rise/fall strobes
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~edge_q;
    assign fall  = ~level & edge_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an asynchronous PWM input
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                 pwm_clk,
    input  logic                 pwm_reset,
    input  logic                 cap_en,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] cap_value,
    output logic [CNT_WIDTH-1:0] cap_period,
    output logic                 cap_valid,
    output logic                 cap_timeout,
    output logic                 cap_level
);

    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_END = CNT_MAX - ONE;

    logic                 level;
    logic                 rise;
    logic                 fall;
    pwm_state_t           state;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic [CNT_WIDTH-1:0] high_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    pwm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (pwm_clk),
        .resetn (pwm_reset),
        .din    (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    // period_cnt doubles as the no-edge timer while waiting for the first rise.
    always_ff @(posedge pwm_clk) begin
        if (!pwm_reset) begin
            state       <= IDLE;
            period_cnt  <= '0;
            high_cnt    <= '0;
            cap_value   <= '0;
            cap_period  <= '0;
            cap_valid   <= 1'b0;
            cap_timeout <= 1'b0;
            cap_level   <= 1'b0;
        end else begin
            cap_valid   <= 1'b0;
            cap_timeout <= 1'b0;
            cap_level   <= level;
            if (!cap_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= WAIT_RISE;
                        period_cnt <= '0;
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            state      <= HIGH;
                            period_cnt <= ONE;
                            high_cnt   <= ONE;
                        end else if (period_cnt == CNT_END) begin
                            cap_timeout <= 1'b1;
                            cap_value   <= '0;
                            cap_period  <= '0;
                            period_cnt  <= '0;
                        end else begin
                            period_cnt <= sat_inc(period_cnt);
                        end
                    end
                    HIGH, LOW: begin
                        if (rise) begin
                            // A rise while still HIGH means the low pulse was lost.
                            cap_valid  <= 1'b1;
                            cap_period <= period_cnt;
                            cap_value  <= (state == HIGH) ? period_cnt : high_cnt;
                            period_cnt <= ONE;
                            high_cnt   <= ONE;
                            state      <= HIGH;
                        end else if (period_cnt == CNT_END) begin
                            cap_timeout <= 1'b1;
                            cap_value   <= '0;
                            cap_period  <= '0;
                            period_cnt  <= '0;
                            state       <= WAIT_RISE;
                        end else begin
                            period_cnt <= sat_inc(period_cnt);
                            if (state == HIGH) begin
                                if (fall) begin
                                    state <= LOW;
                                end else begin
                                    high_cnt <= sat_inc(high_cnt);
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized and directed checks of pwm_capture against a timing model
module tb_pwm_capture;

    localparam int W = 8;

    logic         pwm_clk   = 1'b0;
    logic         pwm_reset = 1'b0;
    logic         cap_en    = 1'b0;
    logic         pwm_in    = 1'b0;
    logic [W-1:0] cap_value;
    logic [W-1:0] cap_period;
    logic         cap_valid;
    logic         cap_timeout;
    logic         cap_level;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int value;
        int period;
        int at;
    } cap_t;

    cap_t obs_q[$];
    cap_t exp_q[$];
    int   tmo_q[$];

    // Waveform model: time in driven cycles, captures derived from rise/fall instants.
    int t       = 0;
    bit lvl_prev = 1'b0;
    bit armed   = 1'b0;
    int rise_t  = 0;
    int fall_t  = 0;

    pwm_capture #(
        .CNT_WIDTH   (W),
        .SYNC_STAGES (2)
    ) dut (
        .pwm_clk     (pwm_clk),
        .pwm_reset   (pwm_reset),
        .cap_en      (cap_en),
        .pwm_in      (pwm_in),
        .cap_value   (cap_value),
        .cap_period  (cap_period),
        .cap_valid   (cap_valid),
        .cap_timeout (cap_timeout),
        .cap_level   (cap_level)
    );

    always #5 pwm_clk = ~pwm_clk;

    always @(posedge pwm_clk) cyc <= cyc + 1;

    always @(negedge pwm_clk) begin
        cap_t c;
        if (cap_valid) begin
            c.value  = int'(cap_value);
            c.period = int'(cap_period);
            c.at     = cyc;
            obs_q.push_back(c);
        end
        if (cap_timeout) tmo_q.push_back(cyc);
    end

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input bit lvl, input int n);
        cap_t c;
        for (int i = 0; i < n; i++) begin
            if (lvl && !lvl_prev) begin
                if (cap_en && armed) begin
                    c.value  = fall_t - rise_t;
                    c.period = t - rise_t;
                    c.at     = 0;
                    exp_q.push_back(c);
                end
                if (cap_en) armed = 1'b1;
                rise_t = t;
            end else if (!lvl && lvl_prev) begin
                fall_t = t;
            end
            lvl_prev = lvl;
            pwm_in   = lvl;
            @(posedge pwm_clk);
            #1;
            t++;
        end
    endtask

    task automatic wave(input int high, input int low, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, high);
            drive(1'b0, low);
        end
    endtask

    task automatic compare_caps(input string tag, input int spacing);
        drive(1'b0, 8);
        check({tag, ":count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s:value[%0d]", tag, i), obs_q[i].value, exp_q[i].value);
            check($sformatf("%s:period[%0d]", tag, i), obs_q[i].period, exp_q[i].period);
        end
        if (spacing > 0) begin
            for (int i = 1; i < obs_q.size(); i++)
                check($sformatf("%s:spacing[%0d]", tag, i), obs_q[i].at - obs_q[i-1].at, spacing);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit seen;

        // Reset state
        repeat (3) @(posedge pwm_clk);
        #1;
        check("reset:cap_value", int'(cap_value), 0);
        check("reset:cap_period", int'(cap_period), 0);
        check("reset:cap_valid", int'(cap_valid), 0);
        check("reset:cap_timeout", int'(cap_timeout), 0);
        check("reset:cap_level", int'(cap_level), 0);
        pwm_reset = 1'b1;
        cap_en    = 1'b1;
        drive(1'b0, 4);

        // 25/75 steady waveform
        wave(25, 75, 4);
        drive(1'b1, 3);
        compare_caps("w25_75", 100);

        // Minimum 1/1 waveform
        wave(1, 1, 8);
        drive(1'b1, 1);
        compare_caps("w1_1", 2);

        // Loop-back style 50/200
        wave(50, 150, 3);
        drive(1'b1, 1);
        compare_caps("w50_200", 200);

        // Random cycle-by-cycle waveform
        for (int k = 0; k < 16; k++)
            wave(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), 1);
        drive(1'b1, 1);
        compare_caps("random", 0);

        // Reset in the middle of a high phase
        wave(3, 5, 3);
        compare_caps("w3_5_pre", 0);
        drive(1'b1, 1);
        pwm_reset = 1'b0;
        drive(1'b1, 1);
        check("midreset:cap_value", int'(cap_value), 0);
        check("midreset:cap_period", int'(cap_period), 0);
        check("midreset:cap_valid", int'(cap_valid), 0);
        check("midreset:cap_timeout", int'(cap_timeout), 0);
        check("midreset:cap_level", int'(cap_level), 0);
        drive(1'b1, 1);
        drive(1'b0, 2);
        pwm_reset = 1'b1;
        armed     = 1'b0;
        obs_q.delete();
        exp_q.delete();
        drive(1'b0, 3);
        wave(3, 5, 4);
        drive(1'b1, 1);
        compare_caps("w3_5_post", 8);

        // Capture enable dropped during a low phase
        wave(10, 20, 3);
        compare_caps("w10_30", 0);
        cap_en = 1'b0;
        armed  = 1'b0;
        drive(1'b0, 5);
        check("disable:cap_value", int'(cap_value), 10);
        check("disable:cap_period", int'(cap_period), 30);
        cap_en = 1'b1;
        drive(1'b0, 6);
        check("disable:no_valid", obs_q.size(), 0);
        wave(10, 20, 3);
        drive(1'b1, 1);
        compare_caps("reenable", 30);

        // Stuck-high input: timeouts every 2^W-1 cycles
        tmo_q.delete();
        seen = 1'b0;
        drive(1'b1, 4);
        for (int i = 0; i < 900 && tmo_q.size() < 3; i++) begin
            drive(1'b1, 1);
            if (cap_timeout && !seen) begin
                seen = 1'b1;
                check("timeout:cap_value", int'(cap_value), 0);
                check("timeout:cap_period", int'(cap_period), 0);
                check("timeout:cap_level", int'(cap_level), 1);
            end
        end
        check("timeout:count", tmo_q.size(), 3);
        if (tmo_q.size() >= 3) begin
            check("timeout:spacing1", tmo_q[1] - tmo_q[0], 255);
            check("timeout:spacing2", tmo_q[2] - tmo_q[1], 255);
        end
        compare_caps("stuck_high", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
